c5efa7_enet_pll_lock_supervisor: RTL and testbench

//  Reset/lock supervisor wrapped around the Ethernet PLL (50 MHz ref -> 125/25/2.5 MHz).

---
 rtl/c5efa7_enet_pll_lock_supervisor.sv | 139 +++++++++++++
 tb/tb_c5efa7_enet_pll_lock_supervisor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/c5efa7_enet_pll_lock_supervisor.sv
// Reset/lock supervisor for the Ethernet PLL: sequences pll_rst, qualifies lock,
// retries on timeout and holds downstream logic in reset until lock is stable.
module c5efa7_enet_pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 7,
    parameter int CNT_W              = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       retry_nxt;
    logic             lock_meta, lock_s;

    // pll_locked comes from the PLL's own analog timing, so it is treated as asynchronous.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry_count <= 3'd0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            // Outputs decode the next state so they move on the same edge as the state.
            pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAIL);
            sys_rst     <= (state_nxt != S_RUN);
            ready       <= (state_nxt == S_RUN);
            fail        <= (state_nxt == S_FAIL);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_count;
        if (force_relock) begin
            state_nxt = S_RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = 3'd0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a timeout landing in the same cycle.
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_nxt = '0;
                        if (retry_count == RETRY_MAX) begin
                            state_nxt = S_FAIL;
                        end else begin
                            state_nxt = S_RESET_PLL;
                            retry_nxt = retry_count + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_RESET_PLL;
                        cnt_nxt   = '0;
                        retry_nxt = 3'd0;
                    end
                end
                S_FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = S_RESET_PLL;
                    cnt_nxt   = '0;
                    retry_nxt = 3'd0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_c5efa7_enet_pll_lock_supervisor.sv
// Directed bench for the PLL lock supervisor with short timing parameters
// (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2).
module tb_c5efa7_enet_pll_lock_supervisor;

    localparam logic [7:0] ST_RESET_PLL = 8'd0;
    localparam logic [7:0] ST_WAIT_LOCK = 8'd1;
    localparam logic [7:0] ST_STABLE    = 8'd2;
    localparam logic [7:0] ST_RUN       = 8'd3;
    localparam logic [7:0] ST_FAIL      = 8'd4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [2:0] retry_count;
    logic [2:0] state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    c5efa7_enet_pll_lock_supervisor #(
        .PLL_RST_CYCLES    (4),
        .LOCK_TIMEOUT      (32),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (2),
        .CNT_W             (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        edge_n++;
    endtask

    task automatic to_edge(input int k);
        while (edge_n < k) tick();
    endtask

    // Edge numbering restarts at 1 for the first edge after reset release.
    task automatic do_reset();
        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("rst_sys_rst", {7'd0, sys_rst}, 8'd1);
        chk("rst_ready", {7'd0, ready}, 8'd0);
        chk("rst_fail", {7'd0, fail}, 8'd0);
        chk("rst_retry", {5'd0, retry_count}, 8'd0);
        chk("rst_state", {5'd0, state_dbg}, ST_RESET_PLL);

        // 1: normal lock, ready 10 edges after the first sampling edge (edge 5)
        do_reset();
        to_edge(3);
        chk("t1_pll_rst_e3", {7'd0, pll_rst}, 8'd1);
        to_edge(4);
        chk("t1_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
        chk("t1_state_e4", {5'd0, state_dbg}, ST_WAIT_LOCK);
        pll_locked = 1'b1;
        to_edge(7);
        chk("t1_state_e7", {5'd0, state_dbg}, ST_STABLE);
        to_edge(14);
        chk("t1_ready_e14", {7'd0, ready}, 8'd0);
        chk("t1_sys_rst_e14", {7'd0, sys_rst}, 8'd1);
        to_edge(15);
        chk("t1_ready_e15", {7'd0, ready}, 8'd1);
        chk("t1_sys_rst_e15", {7'd0, sys_rst}, 8'd0);
        chk("t1_pll_rst_e15", {7'd0, pll_rst}, 8'd0);
        chk("t1_retry_e15", {5'd0, retry_count}, 8'd0);

        // 4: lock loss in RUN, first sampled at edge 16
        pll_locked = 1'b0;
        to_edge(17);
        chk("t4_ready_e17", {7'd0, ready}, 8'd1);
        to_edge(18);
        chk("t4_sys_rst_e18", {7'd0, sys_rst}, 8'd1);
        chk("t4_ready_e18", {7'd0, ready}, 8'd0);
        chk("t4_pll_rst_e18", {7'd0, pll_rst}, 8'd1);
        chk("t4_retry_e18", {5'd0, retry_count}, 8'd0);
        to_edge(21);
        chk("t4_pll_rst_e21", {7'd0, pll_rst}, 8'd1);
        to_edge(22);
        chk("t4_pll_rst_e22", {7'd0, pll_rst}, 8'd0);
        pll_locked = 1'b1;
        to_edge(32);
        chk("t4_ready_e32", {7'd0, ready}, 8'd0);
        to_edge(33);
        chk("t4_ready_e33", {7'd0, ready}, 8'd1);

        // 3: one-cycle lock glitch inside the stable window
        do_reset();
        to_edge(4);
        pll_locked = 1'b1;
        to_edge(11);
        pll_locked = 1'b0;
        to_edge(12);
        pll_locked = 1'b1;
        to_edge(13);
        chk("t3_sys_rst_e13", {7'd0, sys_rst}, 8'd1);
        to_edge(14);
        chk("t3_state_e14", {5'd0, state_dbg}, ST_WAIT_LOCK);
        chk("t3_sys_rst_e14", {7'd0, sys_rst}, 8'd1);
        to_edge(15);
        chk("t3_state_e15", {5'd0, state_dbg}, ST_STABLE);
        to_edge(22);
        chk("t3_ready_e22", {7'd0, ready}, 8'd0);
        chk("t3_sys_rst_e22", {7'd0, sys_rst}, 8'd1);
        to_edge(23);
        chk("t3_ready_e23", {7'd0, ready}, 8'd1);
        chk("t3_sys_rst_e23", {7'd0, sys_rst}, 8'd0);

        // 2: no lock ever -> two retries then FAIL
        do_reset();
        to_edge(35);
        chk("t2_retry_e35", {5'd0, retry_count}, 8'd0);
        chk("t2_pll_rst_e35", {7'd0, pll_rst}, 8'd0);
        to_edge(36);
        chk("t2_retry_e36", {5'd0, retry_count}, 8'd1);
        chk("t2_pll_rst_e36", {7'd0, pll_rst}, 8'd1);
        to_edge(39);
        chk("t2_pll_rst_e39", {7'd0, pll_rst}, 8'd1);
        to_edge(40);
        chk("t2_pll_rst_e40", {7'd0, pll_rst}, 8'd0);
        to_edge(71);
        chk("t2_retry_e71", {5'd0, retry_count}, 8'd1);
        to_edge(72);
        chk("t2_retry_e72", {5'd0, retry_count}, 8'd2);
        chk("t2_pll_rst_e72", {7'd0, pll_rst}, 8'd1);
        to_edge(107);
        chk("t2_fail_e107", {7'd0, fail}, 8'd0);
        chk("t2_pll_rst_e107", {7'd0, pll_rst}, 8'd0);
        to_edge(108);
        chk("t2_fail_e108", {7'd0, fail}, 8'd1);
        chk("t2_pll_rst_e108", {7'd0, pll_rst}, 8'd1);
        chk("t2_sys_rst_e108", {7'd0, sys_rst}, 8'd1);
        chk("t2_retry_e108", {5'd0, retry_count}, 8'd2);
        chk("t2_state_e108", {5'd0, state_dbg}, ST_FAIL);
        to_edge(1108);
        chk("t2_fail_hold", {7'd0, fail}, 8'd1);
        chk("t2_state_hold", {5'd0, state_dbg}, ST_FAIL);
        chk("t2_ready_hold", {7'd0, ready}, 8'd0);

        // 5a: force_relock out of FAIL
        force_relock = 1'b1;
        to_edge(1109);
        force_relock = 1'b0;
        chk("t5_fail_f0", {7'd0, fail}, 8'd0);
        chk("t5_retry_f0", {5'd0, retry_count}, 8'd0);
        chk("t5_pll_rst_f0", {7'd0, pll_rst}, 8'd1);
        chk("t5_state_f0", {5'd0, state_dbg}, ST_RESET_PLL);
        to_edge(1112);
        chk("t5_pll_rst_f3", {7'd0, pll_rst}, 8'd1);
        to_edge(1113);
        chk("t5_pll_rst_f4", {7'd0, pll_rst}, 8'd0);

        // 5b: force_relock on the same edge as the first timeout
        do_reset();
        to_edge(35);
        force_relock = 1'b1;
        to_edge(36);
        force_relock = 1'b0;
        chk("t5b_retry_e36", {5'd0, retry_count}, 8'd0);
        chk("t5b_state_e36", {5'd0, state_dbg}, ST_RESET_PLL);
        to_edge(39);
        chk("t5b_pll_rst_e39", {7'd0, pll_rst}, 8'd1);
        to_edge(40);
        chk("t5b_state_e40", {5'd0, state_dbg}, ST_WAIT_LOCK);

        // 6: asynchronous reset between edges in WAIT_LOCK
        do_reset();
        to_edge(10);
        chk("t6_pll_rst_pre", {7'd0, pll_rst}, 8'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_pll_rst_async", {7'd0, pll_rst}, 8'd1);
        chk("t6_sys_rst_async", {7'd0, sys_rst}, 8'd1);
        chk("t6_state_async", {5'd0, state_dbg}, ST_RESET_PLL);
        do_reset();
        to_edge(3);
        chk("t6_pll_rst_e3", {7'd0, pll_rst}, 8'd1);
        to_edge(4);
        chk("t6_pll_rst_e4", {7'd0, pll_rst}, 8'd0);
        chk("t6_state_e4", {5'd0, state_dbg}, ST_WAIT_LOCK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
